serial_addsub_ctrl: RTL and testbench

//  Bit-serial add/subtract sequencer. Drives one shared 1-bit full add/sub cell LSB-first over WIDTH cycles.

---
 rtl/serial_addsub_pkg.sv | 17 +
 rtl/serial_addsub_ctrl_cell.sv | 23 ++
 rtl/serial_addsub_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer: FSM state codes and mode values.
package serial_addsub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_cell.sv
// Combinational 1-bit full add/subtract cell; c_out is a carry in add mode and a borrow in sub mode.
module addsub_cell
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic mode,
  output logic s,
  output logic c_out
);

  logic carry_add;
  logic borrow_sub;

  always_comb begin
    s          = a ^ b ^ c;
    carry_add  = (a & b) | (a & c) | (b & c);
    borrow_sub = (~a & b) | (~a & c) | (b & c);
    c_out      = (mode == MODE_SUB) ? borrow_sub : carry_add;
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: latches operands on start, feeds one shared cell LSB-first
// over WIDTH cycles, then presents result/cout with a one-cycle done pulse.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               mode_q, mode_d;
  logic               cell_s, cell_c;

  addsub_cell u_cell (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (carry_q),
    .mode  (mode_q),
    .s     (cell_s),
    .c_out (cell_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    mode_d   = mode_q;
    sum_sh_d = sum_sh_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          mode_d  = mode;
          carry_d = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 holds the LSB.
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {cell_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = cell_c;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = sum_sh_d;
          cout_d   = cell_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Operand and partial-sum shifters are always written before being read, so they need no reset.
  always_ff @(posedge clk) begin
    a_sh_q   <= a_sh_d;
    b_sh_q   <= b_sh_d;
    mode_q   <= mode_d;
    sum_sh_q <= sum_sh_d;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed vector table, handshake and reset corner
// sequences, exhaustive back-to-back sweep and randomized operations against an arithmetic model.
module tb_serial_addsub_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int errors = 0;
  int checks = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vm;
    logic [W-1:0] er;
    logic         ec;
  } vec_t;

  vec_t vecs[10];

  // Reference: plain unsigned arithmetic; subtract borrow is simply a < b.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic m);
    logic [W-1:0] d;
    if (!m) return {1'b0, x} + {1'b0, y};
    d = x - y;
    return {(x < y), d};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tm,
                        output logic [W-1:0] r, output logic c, output int lat,
                        output int busy_bad);
    @(negedge clk);
    a = ta; b = tb_; mode = tm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_bad = 0;
    while (done !== 1'b1 && lat <= 3 * W) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b0) busy_bad++;
    r = result;
    c = cout;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r;
    logic         c;
    logic [W:0]   e;
    int           lat, bb, seen;
    logic [W-1:0] pa, pb;
    logic         pm;
    logic [8:0]   idx;

    vecs[0] = '{4'd7,  4'd9,  1'b0, 4'h0, 1'b1};
    vecs[1] = '{4'd3,  4'd4,  1'b0, 4'h7, 1'b0};
    vecs[2] = '{4'd3,  4'd5,  1'b1, 4'hE, 1'b1};
    vecs[3] = '{4'd9,  4'd4,  1'b1, 4'h5, 1'b0};
    vecs[4] = '{4'd6,  4'd6,  1'b1, 4'h0, 1'b0};
    vecs[5] = '{4'd15, 4'd1,  1'b0, 4'h0, 1'b1};
    vecs[6] = '{4'd0,  4'd0,  1'b0, 4'h0, 1'b0};
    vecs[7] = '{4'd15, 4'd15, 1'b0, 4'hE, 1'b1};
    vecs[8] = '{4'd0,  4'd15, 1'b1, 4'h1, 1'b1};
    vecs[9] = '{4'd15, 4'd0,  1'b1, 4'hF, 1'b0};

    // Reset and idle quiescence
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen++;
    end
    check("idle_no_activity", seen, 0);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vm, r, c, lat, bb);
      check($sformatf("vec%0d_result", i), r, vecs[i].er);
      check($sformatf("vec%0d_cout", i), c, vecs[i].ec);
      check($sformatf("vec%0d_latency", i), lat, W + 1);
      check($sformatf("vec%0d_busy", i), bb, 0);
    end

    // start during SHIFT ignored; start in DONE launches back-to-back op
    @(negedge clk);
    a = 4'd2; b = 4'd3; mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;                        // k+1
    @(negedge clk); start = 1'b1; a = 4'd9; b = 4'd9;   // k+2, busy
    seen = 0;
    @(negedge clk); start = 1'b0; if (done) seen++;     // k+3
    @(negedge clk); if (done) seen++;                   // k+4
    check("hs_no_early_done", seen, 0);
    @(negedge clk);                                     // k+5
    check("hs_done", done, 1);
    check("hs_busy_in_done", busy, 0);
    check("hs_result", result, 5);
    start = 1'b1; a = 4'd1; b = 4'd1; mode = 1'b0;
    @(negedge clk); start = 1'b0; a = 4'd7; b = 4'd7; mode = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (done || !busy) seen++;
      @(negedge clk);
    end
    if (done || !busy) seen++;
    check("b2b_busy_window", seen, 0);
    check("b2b_result_held", result, 5);
    @(negedge clk);
    check("b2b_done", done, 1);
    check("b2b_result", result, 2);
    check("b2b_cout", cout, 0);
    @(negedge clk);
    check("done_single_pulse", done, 0);
    check("result_hold_idle", result, 2);

    // Reset in the second SHIFT cycle aborts the operation
    @(negedge clk);
    a = 4'd15; b = 4'd1; mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("midop_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midop_busy", busy, 0);
    check("midop_done", done, 0);
    check("midop_result", result, 0);
    check("midop_cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midop_no_done", seen, 0);
    run_op(4'd15, 4'd1, 1'b0, r, c, lat, bb);
    check("post_rst_result", r, 0);
    check("post_rst_cout", c, 1);
    check("post_rst_latency", lat, W + 1);

    // Exhaustive sweep with back-to-back starts
    @(negedge clk);
    pa = '0; pb = '0; pm = 1'b0;
    a = pa; b = pb; mode = pm; start = 1'b1;
    for (int n = 1; n <= 512; n++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (done !== 1'b1 && lat < 3 * W);
      e = model(pa, pb, pm);
      check($sformatf("exh_lat a=%0d b=%0d m=%0d", pa, pb, pm), lat, W + 1);
      check($sformatf("exh a=%0d b=%0d m=%0d", pa, pb, pm), {cout, result}, e);
      if (n < 512) begin
        idx = 9'(n);
        pa = idx[3:0]; pb = idx[7:4]; pm = idx[8];
        a = pa; b = pb; mode = pm;
      end
    end
    start = 1'b0;

    // Randomized operations with random idle gaps
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pa = W'($urandom); pb = W'($urandom); pm = 1'($urandom);
      run_op(pa, pb, pm, r, c, lat, bb);
      e = model(pa, pb, pm);
      check($sformatf("rnd a=%0d b=%0d m=%0d", pa, pb, pm), {c, r}, e);
      check($sformatf("rnd_lat%0d", n), lat, W + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
